// File: rtl/if_stage_if.sv
// Instruction-memory read port between the fetch stage and the instruction memory.
interface if_stage_if;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ready;
    logic [31:0] imem_rdata;

    modport master (
        output imem_req,
        output imem_addr,
        input  imem_ready,
        input  imem_rdata
    );

    modport slave (
        input  imem_req,
        input  imem_addr,
        output imem_ready,
        output imem_rdata
    );
endinterface

// File: rtl/if_stage.sv
// Instruction-fetch stage: owns the PC, issues imem reads and loads IF/ID.
// Redirects flush the wrong-path fetch; an outstanding read is drained before retargeting.
module if_stage #(
    parameter logic [31:0] RESET_PC = 32'h0000_3000
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              stall,
    input  logic              redirect,
    input  logic [31:0]       redirect_pc,
    output logic [31:0]       fetch_pc,
    if_stage_if.master        imem,
    output logic              ifid_valid,
    output logic [31:0]       ifid_pc,
    output logic [31:0]       ifid_pcplus4,
    output logic [31:0]       ifid_instr
);

    typedef enum logic [1:0] {
        FETCH = 2'd0,
        HOLD  = 2'd1,
        DRAIN = 2'd2
    } state_t;

    state_t      state, state_n;
    logic [31:0] pc, pc_n;
    logic [31:0] ibuf, ibuf_n;
    logic [31:0] tgt, tgt_n;
    logic        ifid_valid_n;
    logic [31:0] ifid_pc_n, ifid_pcplus4_n, ifid_instr_n;
    logic [31:0] rpc, pc_plus4;

    assign rpc      = redirect_pc & 32'hFFFF_FFFC;
    assign pc_plus4 = pc + 32'd4;

    // The request must vanish combinationally while reset is held, not on the next edge.
    assign fetch_pc       = pc;
    assign imem.imem_addr = pc;
    assign imem.imem_req  = !rst && (state != HOLD);

    always_comb begin
        state_n        = state;
        pc_n           = pc;
        ibuf_n         = ibuf;
        tgt_n          = tgt;
        ifid_valid_n   = ifid_valid;
        ifid_pc_n      = ifid_pc;
        ifid_pcplus4_n = ifid_pcplus4;
        ifid_instr_n   = ifid_instr;

        unique case (state)
            FETCH: begin
                if (redirect && imem.imem_ready) begin
                    pc_n         = rpc;
                    ifid_valid_n = 1'b0;
                end else if (redirect) begin
                    tgt_n        = rpc;
                    ifid_valid_n = 1'b0;
                    state_n      = DRAIN;
                end else if (stall && imem.imem_ready) begin
                    ibuf_n  = imem.imem_rdata;
                    state_n = HOLD;
                end else if (stall) begin
                    state_n = FETCH;
                end else if (imem.imem_ready) begin
                    ifid_valid_n   = 1'b1;
                    ifid_pc_n      = pc;
                    ifid_pcplus4_n = pc_plus4;
                    ifid_instr_n   = imem.imem_rdata;
                    pc_n           = pc_plus4;
                end else begin
                    ifid_valid_n = 1'b0;
                end
            end

            HOLD: begin
                if (redirect) begin
                    pc_n         = rpc;
                    ifid_valid_n = 1'b0;
                    state_n      = FETCH;
                end else if (!stall) begin
                    ifid_valid_n   = 1'b1;
                    ifid_pc_n      = pc;
                    ifid_pcplus4_n = pc_plus4;
                    ifid_instr_n   = ibuf;
                    pc_n           = pc_plus4;
                    state_n        = FETCH;
                end
            end

            DRAIN: begin
                // A redirect arriving on the completing edge beats the stored target.
                ifid_valid_n = 1'b0;
                if (redirect) begin
                    tgt_n = rpc;
                end
                if (imem.imem_ready) begin
                    pc_n    = redirect ? rpc : tgt;
                    state_n = FETCH;
                end
            end

            default: begin
                state_n = FETCH;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state        <= FETCH;
            pc           <= RESET_PC;
            ibuf         <= 32'd0;
            tgt          <= 32'd0;
            ifid_valid   <= 1'b0;
            ifid_pc      <= 32'd0;
            ifid_pcplus4 <= 32'd0;
            ifid_instr   <= 32'd0;
        end else begin
            state        <= state_n;
            pc           <= pc_n;
            ibuf         <= ibuf_n;
            tgt          <= tgt_n;
            ifid_valid   <= ifid_valid_n;
            ifid_pc      <= ifid_pc_n;
            ifid_pcplus4 <= ifid_pcplus4_n;
            ifid_instr   <= ifid_instr_n;
        end
    end

endmodule

// File: tb/tb_if_stage.sv
// Self-checking bench for if_stage: directed vector table, reset corner cases,
// then random traffic against a behavioural fetch model.
module tb_if_stage;

    localparam logic [31:0] KEY = 32'hA5A5_A5A5;

    logic        clk = 1'b0;
    logic        rst;
    logic        stall;
    logic        redirect;
    logic [31:0] redirect_pc;
    logic [31:0] fetch_pc;
    logic        ifid_valid;
    logic [31:0] ifid_pc, ifid_pcplus4, ifid_instr;

    int checks = 0;
    int errors = 0;

    if_stage_if mem();

    // Memory answers with a word derived from the address so each fetch is identifiable.
    assign mem.imem_rdata = mem.imem_addr ^ KEY;

    if_stage #(.RESET_PC(32'h0000_3000)) dut (
        .clk          (clk),
        .rst          (rst),
        .stall        (stall),
        .redirect     (redirect),
        .redirect_pc  (redirect_pc),
        .fetch_pc     (fetch_pc),
        .imem         (mem.master),
        .ifid_valid   (ifid_valid),
        .ifid_pc      (ifid_pc),
        .ifid_pcplus4 (ifid_pcplus4),
        .ifid_instr   (ifid_instr)
    );

    always #5 clk = ~clk;

    // Behavioural model: a fetched-but-unconsumed word, or a pending retarget waiting on memory.
    logic [31:0] m_pc, m_ipc, m_instr, m_buf, m_tgt;
    logic        m_valid, m_have_buf, m_draining;

    task automatic model_reset();
        m_pc = 32'h0000_3000; m_valid = 1'b0; m_ipc = 32'd0; m_instr = 32'd0;
        m_have_buf = 1'b0; m_buf = 32'd0; m_draining = 1'b0; m_tgt = 32'd0;
    endtask

    task automatic model_emit(input logic [31:0] word);
        m_valid = 1'b1; m_ipc = m_pc; m_instr = word; m_pc = m_pc + 32'd4;
    endtask

    task automatic model_step(input logic s, input logic r, input logic [31:0] t, input logic rdy);
        logic [31:0] target;
        target = {t[31:2], 2'b00};
        if (m_have_buf) begin
            if (r) begin
                m_have_buf = 1'b0; m_pc = target; m_valid = 1'b0;
            end else if (!s) begin
                m_have_buf = 1'b0; model_emit(m_buf);
            end
        end else if (m_draining) begin
            m_valid = 1'b0;
            if (r) m_tgt = target;
            if (rdy) begin
                m_pc = m_tgt; m_draining = 1'b0;
            end
        end else if (r) begin
            m_valid = 1'b0;
            if (rdy) m_pc = target;
            else begin
                m_draining = 1'b1; m_tgt = target;
            end
        end else if (s) begin
            if (rdy) begin
                m_have_buf = 1'b1; m_buf = m_pc ^ KEY;
            end
        end else if (rdy) begin
            model_emit(m_pc ^ KEY);
        end else begin
            m_valid = 1'b0;
        end
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Drive one cycle of inputs, advance the model, and land #1 after the edge.
    task automatic applyStimulus(input logic s, input logic r, input logic [31:0] t, input logic rdy);
        stall = s; redirect = r; redirect_pc = t; mem.imem_ready = rdy;
        model_step(s, r, t, rdy);
        @(posedge clk);
        #1;
    endtask

    task automatic checkOutput(input string tag, input logic exp_valid, input logic [31:0] exp_ipc,
                               input logic [31:0] exp_instr, input logic [31:0] exp_fetch,
                               input logic exp_req);
        check({tag, " ifid_valid"}, {31'd0, ifid_valid}, {31'd0, exp_valid});
        check({tag, " fetch_pc"}, fetch_pc, exp_fetch);
        check({tag, " imem_addr"}, mem.imem_addr, exp_fetch);
        check({tag, " imem_req"}, {31'd0, mem.imem_req}, {31'd0, exp_req});
        if (exp_valid) begin
            check({tag, " ifid_pc"}, ifid_pc, exp_ipc);
            check({tag, " ifid_pcplus4"}, ifid_pcplus4, exp_ipc + 32'd4);
            check({tag, " ifid_instr"}, ifid_instr, exp_instr);
        end
    endtask

    typedef struct packed {
        logic        stall;
        logic        redirect;
        logic [31:0] rpc;
        logic        ready;
        logic        exp_valid;
        logic [31:0] exp_ipc;
        logic [31:0] exp_fetch;
        logic        exp_req;
    } vec_t;

    vec_t vecs [23];

    initial begin
        // stall, redirect, redirect_pc, ready | valid, ifid_pc, fetch_pc, req (ifid_instr = ifid_pc ^ KEY)
        vecs[0]  = '{1'b0, 1'b0, 32'h0,         1'b1, 1'b1, 32'h3000,      32'h3004,      1'b1};
        vecs[1]  = '{1'b0, 1'b0, 32'h0,         1'b1, 1'b1, 32'h3004,      32'h3008,      1'b1};
        vecs[2]  = '{1'b0, 1'b0, 32'h0,         1'b1, 1'b1, 32'h3008,      32'h300C,      1'b1};
        vecs[3]  = '{1'b1, 1'b0, 32'h0,         1'b1, 1'b1, 32'h3008,      32'h300C,      1'b0};
        vecs[4]  = '{1'b1, 1'b0, 32'h0,         1'b1, 1'b1, 32'h3008,      32'h300C,      1'b0};
        vecs[5]  = '{1'b1, 1'b0, 32'h0,         1'b1, 1'b1, 32'h3008,      32'h300C,      1'b0};
        vecs[6]  = '{1'b0, 1'b0, 32'h0,         1'b1, 1'b1, 32'h300C,      32'h3010,      1'b1};
        vecs[7]  = '{1'b0, 1'b1, 32'h3100,      1'b1, 1'b0, 32'h0,         32'h3100,      1'b1};
        vecs[8]  = '{1'b0, 1'b0, 32'h0,         1'b1, 1'b1, 32'h3100,      32'h3104,      1'b1};
        vecs[9]  = '{1'b0, 1'b1, 32'h3010,      1'b1, 1'b0, 32'h0,         32'h3010,      1'b1};
        vecs[10] = '{1'b0, 1'b1, 32'h3200,      1'b0, 1'b0, 32'h0,         32'h3010,      1'b1};
        vecs[11] = '{1'b0, 1'b1, 32'h3300,      1'b0, 1'b0, 32'h0,         32'h3010,      1'b1};
        vecs[12] = '{1'b0, 1'b0, 32'h0,         1'b1, 1'b0, 32'h0,         32'h3300,      1'b1};
        vecs[13] = '{1'b0, 1'b0, 32'h0,         1'b1, 1'b1, 32'h3300,      32'h3304,      1'b1};
        vecs[14] = '{1'b1, 1'b0, 32'h0,         1'b1, 1'b1, 32'h3300,      32'h3304,      1'b0};
        vecs[15] = '{1'b1, 1'b1, 32'h3400,      1'b1, 1'b0, 32'h0,         32'h3400,      1'b1};
        vecs[16] = '{1'b0, 1'b0, 32'h0,         1'b1, 1'b1, 32'h3400,      32'h3404,      1'b1};
        vecs[17] = '{1'b0, 1'b1, 32'hFFFF_FFFF, 1'b1, 1'b0, 32'h0,         32'hFFFF_FFFC, 1'b1};
        vecs[18] = '{1'b0, 1'b0, 32'h0,         1'b1, 1'b1, 32'hFFFF_FFFC, 32'h0000_0000, 1'b1};
        vecs[19] = '{1'b0, 1'b0, 32'h0,         1'b1, 1'b1, 32'h0000_0000, 32'h0000_0004, 1'b1};
        vecs[20] = '{1'b0, 1'b0, 32'h0,         1'b0, 1'b0, 32'h0,         32'h0000_0004, 1'b1};
        vecs[21] = '{1'b1, 1'b0, 32'h0,         1'b0, 1'b0, 32'h0,         32'h0000_0004, 1'b1};
        vecs[22] = '{1'b0, 1'b0, 32'h0,         1'b1, 1'b1, 32'h0000_0004, 32'h0000_0008, 1'b1};

        rst = 1'b1; stall = 1'b0; redirect = 1'b0; redirect_pc = 32'd0; mem.imem_ready = 1'b1;
        model_reset();
        @(posedge clk); @(posedge clk); #1;
        checkOutput("reset", 1'b0, 32'd0, 32'd0, 32'h3000, 1'b0);
        check("reset ifid_pc", ifid_pc, 32'd0);
        check("reset ifid_instr", ifid_instr, 32'd0);
        rst = 1'b0;

        for (int i = 0; i < 23; i++) begin
            applyStimulus(vecs[i].stall, vecs[i].redirect, vecs[i].rpc, vecs[i].ready);
            checkOutput($sformatf("vec%0d", i), vecs[i].exp_valid, vecs[i].exp_ipc,
                        vecs[i].exp_ipc ^ KEY, vecs[i].exp_fetch, vecs[i].exp_req);
        end

        // Reset while draining an outstanding request.
        applyStimulus(1'b0, 1'b1, 32'h3500, 1'b0);
        checkOutput("drain entry", 1'b0, 32'd0, 32'd0, 32'h8, 1'b1);
        rst = 1'b1;
        #1;
        checkOutput("rst mid-drain", 1'b0, 32'd0, 32'd0, 32'h3000, 1'b0);
        model_reset();
        @(posedge clk); #1;
        rst = 1'b0;
        applyStimulus(1'b0, 1'b0, 32'd0, 1'b1);
        checkOutput("post-rst first", 1'b1, 32'h3000, 32'h3000 ^ KEY, 32'h3004, 1'b1);

        // Reset while holding a buffered word.
        applyStimulus(1'b1, 1'b0, 32'd0, 1'b1);
        checkOutput("hold entry", 1'b1, 32'h3000, 32'h3000 ^ KEY, 32'h3004, 1'b0);
        rst = 1'b1;
        #1;
        checkOutput("rst mid-hold", 1'b0, 32'd0, 32'd0, 32'h3000, 1'b0);
        model_reset();
        @(posedge clk); #1;
        rst = 1'b0;

        for (int i = 0; i < 400; i++) begin
            logic s, r, rdy;
            logic [31:0] t;
            s   = ($urandom_range(0, 3) == 0);
            r   = ($urandom_range(0, 9) == 0);
            rdy = ($urandom_range(0, 9) < 7);
            t   = 32'h0000_4000 + {20'd0, 12'($urandom_range(0, 4095))};
            applyStimulus(s, r, t, rdy);
            checkOutput($sformatf("rand%0d", i), m_valid, m_ipc, m_instr, m_pc, !m_have_buf);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
